// File: rtl/led_ring_pkg.sv
// -----------------------------------------------------------------------------
// led_ring_pkg
// Shared types and constants for the four-LED ring indicator.
//   ring_state_e : decoder FSM states (ACQ, TRACK, FAULT)
//   S0..S3       : ring phase codes, one per LED line
//   FWD/REV/SKIP : phase-difference codes (cur - last, mod 4)
// -----------------------------------------------------------------------------
package led_ring_pkg;

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } ring_state_e;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

    localparam logic [1:0] FWD  = 2'd1;
    localparam logic [1:0] REV  = 2'd3;
    localparam logic [1:0] SKIP = 2'd2;

endpackage

// File: rtl/led_onehot_dec.sv
// -----------------------------------------------------------------------------
// led_onehot_dec
// Combinational decoder from the four ring lines to a phase code.
//   i_pat   [3:0] : {led4, led3, led2, led1}
//   o_legal       : exactly one line set
//   o_phase [1:0] : phase of the set line (S0 when not legal)
// -----------------------------------------------------------------------------
module led_onehot_dec
    import led_ring_pkg::*;
(
    input  logic [3:0] i_pat,
    output logic       o_legal,
    output logic [1:0] o_phase
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        o_legal = 1'b0;
        o_phase = S0;
        case (i_pat)
            4'b0001: begin o_legal = 1'b1; o_phase = S0; end
            4'b0010: begin o_legal = 1'b1; o_phase = S1; end
            4'b0100: begin o_legal = 1'b1; o_phase = S2; end
            4'b1000: begin o_legal = 1'b1; o_phase = S3; end
            default: ;
        endcase
    end

endmodule

// File: rtl/led_ring_decoder.sv
// -----------------------------------------------------------------------------
// led_ring_decoder
// Receiver for the four-LED rotating ring: recovers phase, direction and a
// wrapping position count, and flags illegal patterns, skipped phases and
// stalls.
//
// Parameters
//   POS_W     : width of pos
//   STALL_CYC : idle update cycles while tracking before stalled (2..65535)
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   led1..led4          : ring lines for phases S0..S3
//   clr_err             : leaves FAULT (level, only honoured in FAULT)
//   phase [1:0]         : last legal decoded phase
//   dir                 : 1 = forward (S0->S1->S2->S3), 0 = reverse
//   step                : one-cycle pulse per legal step
//   pos [POS_W-1:0]     : wrapping step count
//   valid               : tracking a legal phase
//   err                 : sticky fault flag
//   stalled             : no step for STALL_CYC cycles while tracking
//
// Build option
//   LED_SYNC_EN : adds a two-flop synchronizer per LED line ahead of the
//                 sample register (input-to-step latency 4 edges instead of 2).
// -----------------------------------------------------------------------------
module led_ring_decoder
    import led_ring_pkg::*;
#(
    parameter int POS_W     = 8,
    parameter int STALL_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             led1,
    input  logic             led2,
    input  logic             led3,
    input  logic             led4,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             dir,
    output logic             step,
    output logic [POS_W-1:0] pos,
    output logic             valid,
    output logic             err,
    output logic             stalled
);

    localparam int               CNT_W     = 16;
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_CYC);

    // ---------------- input stage ----------------
    logic [3:0] w_led_in;
    logic [3:0] w_samp_d;
    logic [3:0] r_samp;

    assign w_led_in = {led4, led3, led2, led1};

`ifdef LED_SYNC_EN
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_led_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_samp_d = r_sync2;
`else
    assign w_samp_d = w_led_in;
`endif

    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) r_samp <= '0;
        else       r_samp <= w_samp_d;
    end

    logic       w_legal;
    logic [1:0] w_cur;

    led_onehot_dec u_dec (
        .i_pat   (r_samp),
        .o_legal (w_legal),
        .o_phase (w_cur)
    );

    // ---------------- tracking FSM ----------------
    ring_state_e      r_state,     w_state_nxt;
    logic [1:0]       r_phase,     w_phase_nxt;
    logic             r_dir,       w_dir_nxt;
    logic             r_step,      w_step_nxt;
    logic [POS_W-1:0] r_pos,       w_pos_nxt;
    logic             r_valid,     w_valid_nxt;
    logic             r_err,       w_err_nxt;
    logic             r_stalled,   w_stalled_nxt;
    logic [CNT_W-1:0] r_stall_cnt, w_stall_cnt_nxt;
    logic [1:0]       w_delta;

    // Modulo-4 difference falls out of 2-bit wraparound.
    assign w_delta = w_cur - r_phase;

    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_dir_nxt       = r_dir;
        w_step_nxt      = 1'b0;
        w_pos_nxt       = r_pos;
        w_valid_nxt     = r_valid;
        w_err_nxt       = r_err;
        w_stalled_nxt   = r_stalled;
        w_stall_cnt_nxt = r_stall_cnt;

        case (r_state)
            ACQ: begin
                w_valid_nxt   = 1'b0;
                w_stalled_nxt = 1'b0;
                if (w_legal) begin
                    w_phase_nxt     = w_cur;
                    w_valid_nxt     = 1'b1;
                    w_stall_cnt_nxt = '0;
                    w_state_nxt     = TRACK;
                end
            end

            TRACK: begin
                if (!w_legal || w_delta == SKIP) begin
                    w_err_nxt       = 1'b1;
                    w_valid_nxt     = 1'b0;
                    w_stalled_nxt   = 1'b0;
                    w_stall_cnt_nxt = '0;
                    w_state_nxt     = FAULT;
                end else if (w_delta == FWD || w_delta == REV) begin
                    w_step_nxt      = 1'b1;
                    w_dir_nxt       = (w_delta == FWD);
                    w_pos_nxt       = (w_delta == FWD) ? r_pos + POS_W'(1)
                                                       : r_pos - POS_W'(1);
                    w_phase_nxt     = w_cur;
                    w_stall_cnt_nxt = '0;
                    w_stalled_nxt   = 1'b0;
                end else begin
                    // Same phase as before: count idle cycles, saturating.
                    if (r_stall_cnt != STALL_MAX)
                        w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
                    w_stalled_nxt = (w_stall_cnt_nxt == STALL_MAX);
                end
            end

            FAULT: begin
                w_valid_nxt   = 1'b0;
                w_stalled_nxt = 1'b0;
                if (clr_err) begin
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ACQ;
                end
            end

            default: w_state_nxt = ACQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ACQ;
            r_phase     <= S0;
            r_dir       <= 1'b0;
            r_step      <= 1'b0;
            r_pos       <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_stalled   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_dir       <= w_dir_nxt;
            r_step      <= w_step_nxt;
            r_pos       <= w_pos_nxt;
            r_valid     <= w_valid_nxt;
            r_err       <= w_err_nxt;
            r_stalled   <= w_stalled_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    assign phase   = r_phase;
    assign dir     = r_dir;
    assign step    = r_step;
    assign pos     = r_pos;
    assign valid   = r_valid;
    assign err     = r_err;
    assign stalled = r_stalled;

endmodule

// File: tb/tb_led_ring_decoder.sv
// -----------------------------------------------------------------------------
// tb_led_ring_decoder
// Directed bench for led_ring_decoder with POS_W=8, STALL_CYC=64. Inputs are
// driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_led_ring_decoder;

    localparam int POS_W     = 8;
    localparam int STALL_CYC = 64;
`ifdef LED_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             led1, led2, led3, led4;
    logic             clr_err;
    logic [1:0]       phase;
    logic             dir;
    logic             step;
    logic [POS_W-1:0] pos;
    logic             valid;
    logic             err;
    logic             stalled;

    int n_checks = 0;
    int n_errors = 0;
    int n_steps  = 0;
    int s0;

    always #5 clk = ~clk;

    led_ring_decoder #(
        .POS_W     (POS_W),
        .STALL_CYC (STALL_CYC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .led1    (led1),
        .led2    (led2),
        .led3    (led3),
        .led4    (led4),
        .clr_err (clr_err),
        .phase   (phase),
        .dir     (dir),
        .step    (step),
        .pos     (pos),
        .valid   (valid),
        .err     (err),
        .stalled (stalled)
    );

    // Step pulses are tallied on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (step === 1'b1) n_steps <= n_steps + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_led(input logic [3:0] p);
        {led4, led3, led2, led1} = p;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] pat;

        reset   = 1'b1;
        clr_err = 1'b0;
        set_led(4'b0000);
        tick(3);
        check("rst_valid",   valid,   0);
        check("rst_err",     err,     0);
        check("rst_stalled", stalled, 0);
        check("rst_step",    step,    0);
        check("rst_pos",     pos,     0);
        check("rst_phase",   phase,   0);
        check("rst_dir",     dir,     0);

        // ---- acquire on led1 ----
        reset = 1'b0;
        set_led(4'b0001);
        tick(LAT - 1);
        check("acq_before_latency", valid, 0);
        tick(1);
        check("acq_valid", valid, 1);
        check("acq_phase", phase, 0);
        check("acq_pos",   pos,   0);
        check("acq_step",  step,  0);
        tick(8);
        check("acq_no_step_pulse", n_steps, 0);

        // ---- forward full turn ----
        s0 = n_steps;
        set_led(4'b0010);
        tick(LAT - 1);
        check("fwd_step_not_early", step, 0);
        tick(1);
        check("fwd_step",  step,  1);
        check("fwd_pos1",  pos,   1);
        check("fwd_dir1",  dir,   1);
        check("fwd_phase1", phase, 1);
        tick(1);
        check("fwd_step_one_cycle", step, 0);
        tick(7);
        set_led(4'b0100); tick(10);
        set_led(4'b1000); tick(10);
        set_led(4'b0001); tick(10);
        check("fwd_step_count", n_steps - s0, 4);
        check("fwd_dir",   dir,   1);
        check("fwd_pos",   pos,   4);
        check("fwd_phase", phase, 0);
        check("fwd_valid", valid, 1);

        // ---- reverse from pos 0 ----
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(LAT + 2);
        check("rev_start_pos",   pos,   0);
        check("rev_start_valid", valid, 1);
        s0 = n_steps;
        set_led(4'b1000);
        tick(10);
        check("rev_wrap_pos",  pos,   8'hFF);
        check("rev_dir1",      dir,   0);
        check("rev_phase3",    phase, 3);
        set_led(4'b0100);
        tick(LAT);
        check("rev_step",  step,  1);
        check("rev_pos",   pos,   8'hFE);
        check("rev_dir",   dir,   0);
        check("rev_phase", phase, 2);

        // ---- stall on led3 ----
        tick(STALL_CYC - 1);
        check("stall_not_early", stalled, 0);
        tick(1);
        check("stall_at_limit", stalled, 1);
        check("rev_step_count", n_steps - s0, 2);
        tick(70 - LAT - STALL_CYC);
        check("stall_saturated", stalled, 1);
        check("stall_valid",     valid,   1);
        set_led(4'b1000);
        tick(LAT - 1);
        check("stall_held_before_step", stalled, 1);
        check("stall_no_step_yet",      step,    0);
        tick(1);
        check("stall_clear_step", step,    1);
        check("stall_cleared",    stalled, 0);
        check("stall_exit_pos",   pos,     8'hFF);
        check("stall_exit_dir",   dir,     1);

        // ---- clr_err has no effect while tracking ----
        clr_err = 1'b1;
        tick(3);
        clr_err = 1'b0;
        check("clr_in_track_valid", valid, 1);
        check("clr_in_track_err",   err,   0);

        // ---- skipped phase -> FAULT, recover via multi-hot + clr_err ----
        set_led(4'b0001);
        tick(10);
        check("pre_skip_pos",   pos,   0);
        check("pre_skip_phase", phase, 0);
        set_led(4'b0100);
        tick(LAT);
        check("skip_err",   err,   1);
        check("skip_valid", valid, 0);
        check("skip_step",  step,  0);
        check("skip_pos",   pos,   0);
        check("skip_phase", phase, 0);
        tick(3);
        check("fault_sticky", err, 1);
        set_led(4'b0110);
        tick(LAT);
        check("fault_no_clr", err, 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("clr_err_cleared", err,   0);
        check("clr_valid_low",   valid, 0);
        tick(3);
        check("acq_ignores_multihot", valid, 0);
        check("acq_no_flag",          err,   0);
        set_led(4'b0010);
        tick(LAT);
        check("reacq_valid", valid, 1);
        check("reacq_phase", phase, 1);
        check("reacq_pos",   pos,   0);
        check("reacq_err",   err,   0);

        // ---- forward to pos 17 then reset with a step pending ----
        for (int i = 0; i < 17; i++) begin
            pat = 4'b0001 << ((2 + i) % 4);
            set_led(pat);
            tick(LAT + 1);
        end
        check("run_pos17",   pos,   17);
        check("run_phase",   phase, 2);
        set_led(4'b1000);
        tick(1);
        reset = 1'b1;
        tick(1);
        check("mid_rst_valid",   valid,   0);
        check("mid_rst_step",    step,    0);
        check("mid_rst_pos",     pos,     0);
        check("mid_rst_phase",   phase,   0);
        check("mid_rst_dir",     dir,     0);
        check("mid_rst_err",     err,     0);
        check("mid_rst_stalled", stalled, 0);
        reset = 1'b0;
        tick(LAT - 1);
        check("post_rst_not_yet", valid, 0);
        tick(1);
        check("post_rst_valid", valid, 1);
        check("post_rst_phase", phase, 3);
        check("post_rst_pos",   pos,   0);
        check("post_rst_step",  step,  0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
